// File: rtl/mem_arb_pkg.sv
// rtl/mem_arb_pkg.sv - shared types and constants for the memory port arbiter
package mem_arb_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        RD_WAIT = 2'd1,
        RESP    = 2'd2
    } state_t;

    localparam logic OWN_CPU  = 1'b0;
    localparam logic OWN_HOST = 1'b1;

    localparam int DEF_ADDR_W = 11;
    localparam int DEF_DATA_W = 32;

endpackage

// File: rtl/mem_arb_grant.sv
// rtl/mem_arb_grant.sv - CPU-priority grant with host starvation override
module mem_arb_grant
    import mem_arb_pkg::*;
#(
    parameter int MAX_WAIT = 8
) (
    input  logic clk,
    input  logic rst,
    input  logic idle,
    input  logic cpu_halt,
    input  logic cpu_req_valid,
    input  logic host_req_valid,
    output logic grant_cpu,
    output logic grant_host
);

    localparam logic [7:0] MAX_WAIT_C = 8'(MAX_WAIT);

    logic [7:0] wait_cnt;

    // Grant only in IDLE: halted CPU yields to host, starved host overrides CPU priority
    always_comb begin
        grant_cpu  = 1'b0;
        grant_host = 1'b0;
        if (idle) begin
            if (cpu_halt) begin
                grant_host = host_req_valid;
            end else if (wait_cnt >= MAX_WAIT_C && host_req_valid) begin
                grant_host = 1'b1;
            end else if (cpu_req_valid) begin
                grant_cpu = 1'b1;
            end else begin
                grant_host = host_req_valid;
            end
        end
    end

    // Count consecutive cycles a valid host request goes unaccepted, saturating
    always_ff @(posedge clk) begin
        if (rst) begin
            wait_cnt <= '0;
        end else if (!host_req_valid || grant_host) begin
            wait_cnt <= '0;
        end else if (wait_cnt < MAX_WAIT_C) begin
            wait_cnt <= wait_cnt + 8'd1;
        end
    end

endmodule

// File: rtl/mem_port_arbiter.sv
// rtl/mem_port_arbiter.sv - sequences the shared memory data port between CPU and host
module mem_port_arbiter
    import mem_arb_pkg::*;
#(
    parameter int ADDR_W   = DEF_ADDR_W,
    parameter int DATA_W   = DEF_DATA_W,
    parameter int RD_LAT   = 0,
    parameter int MAX_WAIT = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              cpu_halt,
    input  logic              cpu_req_valid,
    output logic              cpu_req_ready,
    input  logic              cpu_req_wen,
    input  logic [ADDR_W-1:0] cpu_req_addr,
    input  logic [DATA_W-1:0] cpu_req_wdata,
    output logic              cpu_rsp_valid,
    output logic [DATA_W-1:0] cpu_rsp_rdata,
    input  logic              host_req_valid,
    output logic              host_req_ready,
    input  logic              host_req_wen,
    input  logic [ADDR_W-1:0] host_req_addr,
    input  logic [DATA_W-1:0] host_req_wdata,
    output logic              host_rsp_valid,
    output logic [DATA_W-1:0] host_rsp_rdata,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_wren,
    output logic              mem_rden,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic [31:0]       conflict_cnt
);

    state_t            state;
    state_t            state_nxt;
    logic              idle;
    logic              grant_cpu;
    logic              grant_host;
    logic              grant_any;
    logic              sel_wen;
    logic              owner;
    logic              respond_now;
    logic              resp_owner;
    logic              cpu_rsp_q;
    logic              host_rsp_q;
    logic [DATA_W-1:0] rsp_data;
    logic [31:0]       conflict_q;

    // Reset holds the port quiet even if requesters keep valid high
    assign idle = (state == IDLE) && !rst;

    mem_arb_grant #(.MAX_WAIT(MAX_WAIT)) u_grant (
        .clk            (clk),
        .rst            (rst),
        .idle           (idle),
        .cpu_halt       (cpu_halt),
        .cpu_req_valid  (cpu_req_valid),
        .host_req_valid (host_req_valid),
        .grant_cpu      (grant_cpu),
        .grant_host     (grant_host)
    );

    assign grant_any      = grant_cpu | grant_host;
    assign sel_wen        = grant_host ? host_req_wen : cpu_req_wen;
    assign cpu_req_ready  = grant_cpu;
    assign host_req_ready = grant_host;
    assign mem_addr       = grant_host ? host_req_addr : cpu_req_addr;
    assign mem_wdata      = grant_host ? host_req_wdata : cpu_req_wdata;
    assign mem_wren       = grant_any & sel_wen;
    assign mem_rden       = grant_any & ~sel_wen;

    // Writes finish immediately; reads block the port until their response cycle
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (grant_any && !sel_wen) state_nxt = (RD_LAT == 1) ? RD_WAIT : RESP;
            RD_WAIT: state_nxt = RESP;
            RESP:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Capture point for the response: write/zero-latency read at grant, registered read one cycle later
    assign respond_now = (grant_any && (sel_wen || (RD_LAT == 0))) || (state == RD_WAIT);
    assign resp_owner  = (state == RD_WAIT) ? owner : (grant_host ? OWN_HOST : OWN_CPU);

    // State, owner, response pulse and conflict counter registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            owner      <= OWN_CPU;
            cpu_rsp_q  <= 1'b0;
            host_rsp_q <= 1'b0;
            rsp_data   <= '0;
            conflict_q <= '0;
        end else begin
            state      <= state_nxt;
            cpu_rsp_q  <= 1'b0;
            host_rsp_q <= 1'b0;
            if (grant_any) begin
                owner <= grant_host ? OWN_HOST : OWN_CPU;
            end
            if (respond_now) begin
                rsp_data   <= (grant_any && sel_wen) ? '0 : mem_rdata;
                cpu_rsp_q  <= (resp_owner == OWN_CPU);
                host_rsp_q <= (resp_owner == OWN_HOST);
            end
            if (state == IDLE && cpu_req_valid && host_req_valid && !cpu_halt) begin
                conflict_q <= conflict_q + 32'd1;
            end
        end
    end

    // A response already registered when reset arrives is discarded
    assign cpu_rsp_valid  = cpu_rsp_q & ~rst;
    assign host_rsp_valid = host_rsp_q & ~rst;
    assign cpu_rsp_rdata  = cpu_rsp_valid ? rsp_data : '0;
    assign host_rsp_rdata = host_rsp_valid ? rsp_data : '0;
    assign conflict_cnt   = conflict_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb/tb_mem_port_arbiter.sv - scoreboard bench for mem_port_arbiter at RD_LAT 0 and 1
module tb_mem_port_arbiter;

    logic        clk = 1'b0;
    int          cyc = 0;
    int          n_checks = 0;
    int          n_fail = 0;
    bit          halt_ready_seen = 1'b0;

    logic        rst [2];
    logic        cpu_halt [2];
    logic        cpu_req_valid [2];
    logic        cpu_req_ready [2];
    logic        cpu_req_wen [2];
    logic [10:0] cpu_req_addr [2];
    logic [31:0] cpu_req_wdata [2];
    logic        cpu_rsp_valid [2];
    logic [31:0] cpu_rsp_rdata [2];
    logic        host_req_valid [2];
    logic        host_req_ready [2];
    logic        host_req_wen [2];
    logic [10:0] host_req_addr [2];
    logic [31:0] host_req_wdata [2];
    logic        host_rsp_valid [2];
    logic [31:0] host_rsp_rdata [2];
    logic [10:0] mem_addr [2];
    logic        mem_wren [2];
    logic        mem_rden [2];
    logic [31:0] mem_wdata [2];
    logic [31:0] mem_rdata [2];
    logic [31:0] conflict_cnt [2];

    logic [31:0] mem0 [2048];
    logic [31:0] mem1 [2048];
    logic [31:0] rd1_q;

    typedef struct {
        int          cyc;
        logic [31:0] data;
    } exp_t;

    exp_t q_cpu0[$];
    exp_t q_cpu1[$];
    exp_t q_host0[$];
    exp_t q_host1[$];

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    for (genvar g = 0; g < 2; g++) begin : g_dut
        mem_port_arbiter #(.ADDR_W(11), .DATA_W(32), .RD_LAT(g), .MAX_WAIT(8)) dut (
            .clk            (clk),
            .rst            (rst[g]),
            .cpu_halt       (cpu_halt[g]),
            .cpu_req_valid  (cpu_req_valid[g]),
            .cpu_req_ready  (cpu_req_ready[g]),
            .cpu_req_wen    (cpu_req_wen[g]),
            .cpu_req_addr   (cpu_req_addr[g]),
            .cpu_req_wdata  (cpu_req_wdata[g]),
            .cpu_rsp_valid  (cpu_rsp_valid[g]),
            .cpu_rsp_rdata  (cpu_rsp_rdata[g]),
            .host_req_valid (host_req_valid[g]),
            .host_req_ready (host_req_ready[g]),
            .host_req_wen   (host_req_wen[g]),
            .host_req_addr  (host_req_addr[g]),
            .host_req_wdata (host_req_wdata[g]),
            .host_rsp_valid (host_rsp_valid[g]),
            .host_rsp_rdata (host_rsp_rdata[g]),
            .mem_addr       (mem_addr[g]),
            .mem_wren       (mem_wren[g]),
            .mem_rden       (mem_rden[g]),
            .mem_wdata      (mem_wdata[g]),
            .mem_rdata      (mem_rdata[g]),
            .conflict_cnt   (conflict_cnt[g])
        );
    end

    assign mem_rdata[0] = mem0[mem_addr[0]];
    assign mem_rdata[1] = rd1_q;

    // Memory models: instance 0 reads combinationally, instance 1 through a register
    always @(posedge clk) begin
        if (rst[0]) mem0[4] <= 32'h1234_5678;
        else if (mem_wren[0]) mem0[mem_addr[0]] <= mem_wdata[0];
        if (rst[1]) begin
            mem1[4] <= 32'h1234_5678;
            mem1[8] <= 32'hA5A5_0008;
        end else begin
            if (mem_wren[1]) mem1[mem_addr[1]] <= mem_wdata[1];
            if (mem_rden[1]) rd1_q <= mem1[mem_addr[1]];
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, required 0x%08h", name, act, exp);
        end
    endtask

    task automatic push_exp(input int d, input bit host, input int c, input logic [31:0] v);
        exp_t e;
        e.cyc  = c;
        e.data = v;
        case ({d[0], host})
            2'b00: q_cpu0.push_back(e);
            2'b01: q_host0.push_back(e);
            2'b10: q_cpu1.push_back(e);
            default: q_host1.push_back(e);
        endcase
    endtask

    task automatic check_rsp(input int d, input bit host, input logic [31:0] act);
        exp_t e;
        bit   have = 1'b0;
        string who;
        who = $sformatf("dut%0d_%s", d, host ? "host" : "cpu");
        case ({d[0], host})
            2'b00: if (q_cpu0.size() > 0) begin e = q_cpu0.pop_front(); have = 1'b1; end
            2'b01: if (q_host0.size() > 0) begin e = q_host0.pop_front(); have = 1'b1; end
            2'b10: if (q_cpu1.size() > 0) begin e = q_cpu1.pop_front(); have = 1'b1; end
            default: if (q_host1.size() > 0) begin e = q_host1.pop_front(); have = 1'b1; end
        endcase
        if (!have) begin
            n_checks++;
            n_fail++;
            $display("FAIL %s_unexpected_rsp: got rsp 0x%08h at cycle %0d, required none", who, act, cyc);
        end else begin
            check({who, "_rsp_cycle"}, cyc, e.cyc);
            check({who, "_rsp_data"}, act, e.data);
        end
    endtask

    // Monitor: every response pulse is matched against the scoreboard
    always @(negedge clk) begin
        for (int d = 0; d < 2; d++) begin
            if (cpu_rsp_valid[d]) check_rsp(d, 1'b0, cpu_rsp_rdata[d]);
            if (host_rsp_valid[d]) check_rsp(d, 1'b1, host_rsp_rdata[d]);
        end
        if (cpu_halt[0] && cpu_req_ready[0]) halt_ready_seen = 1'b1;
    end

    task automatic idle_cycles(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic do_req(input int d, input bit host, input bit wen, input logic [10:0] addr,
                          input logic [31:0] wdata, input logic [31:0] exp,
                          output int stalls, output int acc_cyc);
        int lat;
        bit got = 1'b0;
        lat = wen ? 1 : ((d == 0) ? 1 : 2);
        stalls  = 0;
        acc_cyc = -1;
        if (host) begin
            host_req_wen[d] = wen; host_req_addr[d] = addr; host_req_wdata[d] = wdata;
            host_req_valid[d] = 1'b1;
        end else begin
            cpu_req_wen[d] = wen; cpu_req_addr[d] = addr; cpu_req_wdata[d] = wdata;
            cpu_req_valid[d] = 1'b1;
        end
        for (int i = 0; i < 100 && !got; i++) begin
            @(negedge clk);
            if (host ? host_req_ready[d] : cpu_req_ready[d]) begin
                got = 1'b1;
                acc_cyc = cyc;
                push_exp(d, host, cyc + lat, wen ? 32'h0 : exp);
            end else begin
                stalls++;
            end
        end
        if (!got) check($sformatf("dut%0d_%s_accept_timeout", d, host ? "host" : "cpu"), 32'd0, 32'd1);
        @(posedge clk);
        #1;
        if (host) host_req_valid[d] = 1'b0;
        else cpu_req_valid[d] = 1'b0;
    endtask

    initial begin
        int s_c, s_h, a_c, a_h, b;
        for (int d = 0; d < 2; d++) begin
            rst[d] = 1'b1; cpu_halt[d] = 1'b0;
            cpu_req_valid[d] = 1'b0; cpu_req_wen[d] = 1'b0; cpu_req_addr[d] = '0; cpu_req_wdata[d] = '0;
            host_req_valid[d] = 1'b0; host_req_wen[d] = 1'b0; host_req_addr[d] = '0; host_req_wdata[d] = '0;
        end
        idle_cycles(3);
        rst[0] = 1'b0;
        rst[1] = 1'b0;

        // Reset state
        @(negedge clk);
        for (int d = 0; d < 2; d++) begin
            check($sformatf("dut%0d_reset_ready", d), {30'd0, cpu_req_ready[d], host_req_ready[d]}, 32'd0);
            check($sformatf("dut%0d_reset_rsp", d), {30'd0, cpu_rsp_valid[d], host_rsp_valid[d]}, 32'd0);
            check($sformatf("dut%0d_reset_mem_en", d), {30'd0, mem_wren[d], mem_rden[d]}, 32'd0);
            check($sformatf("dut%0d_reset_conflict", d), conflict_cnt[d], 32'd0);
        end
        idle_cycles(1);

        // Halted CPU: host owns the port, CPU never sees ready
        cpu_halt[0] = 1'b1;
        cpu_req_wen[0] = 1'b0; cpu_req_addr[0] = 11'h004; cpu_req_valid[0] = 1'b1;
        do_req(0, 1'b1, 1'b1, 11'h010, 32'hDEAD_BEEF, 32'h0, s_h, a_h);
        do_req(0, 1'b1, 1'b0, 11'h010, 32'h0, 32'hDEAD_BEEF, s_h, a_h);
        idle_cycles(2);
        check("halt_cpu_ready_seen", {31'd0, halt_ready_seen}, 32'd0);
        check("halt_conflict_cnt", conflict_cnt[0], 32'd0);
        cpu_req_valid[0] = 1'b0;
        cpu_halt[0] = 1'b0;
        idle_cycles(2);

        // CPU read, zero and one cycle read latency
        do_req(0, 1'b0, 1'b0, 11'h004, 32'h0, 32'h1234_5678, s_c, a_c);
        check("cpu_read_lat0_stalls", s_c, 0);
        do_req(1, 1'b0, 1'b0, 11'h004, 32'h0, 32'h1234_5678, s_c, a_c);
        check("cpu_read_lat1_stalls", s_c, 0);
        idle_cycles(3);

        // Starvation: CPU writes every cycle, host read must win after MAX_WAIT stalls
        fork
            begin
                for (int i = 0; i < 12; i++) begin
                    int s_l, a_l;
                    do_req(0, 1'b0, 1'b1, 11'h100 + 11'(i), 32'hC000_0000 + i, 32'h0, s_l, a_l);
                end
            end
            do_req(0, 1'b1, 1'b0, 11'h010, 32'h0, 32'hDEAD_BEEF, s_h, a_h);
        join
        check("starve_host_stalls", s_h, 8);
        check("starve_conflict_cnt", conflict_cnt[0], 32'd9);
        idle_cycles(3);

        // Simultaneous writes to one address: CPU first, host second
        fork
            do_req(0, 1'b0, 1'b1, 11'h020, 32'hAAAA_1111, 32'h0, s_c, a_c);
            do_req(0, 1'b1, 1'b1, 11'h020, 32'hBBBB_2222, 32'h0, s_h, a_h);
        join
        check("dual_write_cpu_stalls", s_c, 0);
        check("dual_write_host_after_cpu", a_h - a_c, 1);
        idle_cycles(1);
        do_req(0, 1'b0, 1'b0, 11'h020, 32'h0, 32'hBBBB_2222, s_c, a_c);
        idle_cycles(3);

        // Reset in the cycle after a CPU read is accepted discards the response
        cpu_req_wen[0] = 1'b0; cpu_req_addr[0] = 11'h004; cpu_req_valid[0] = 1'b1;
        b = 0;
        do begin
            @(negedge clk);
            b++;
        end while (!cpu_req_ready[0] && b < 20);
        check("rst_mid_read_accepted", {31'd0, cpu_req_ready[0]}, 32'd1);
        @(posedge clk);
        #1;
        cpu_req_valid[0] = 1'b0;
        rst[0] = 1'b1;
        @(negedge clk);
        check("rst_mid_rsp_valid", {31'd0, cpu_rsp_valid[0]}, 32'd0);
        check("rst_mid_rsp_rdata", cpu_rsp_rdata[0], 32'd0);
        @(posedge clk);
        #1;
        rst[0] = 1'b0;
        @(negedge clk);
        check("rst_after_conflict_cnt", conflict_cnt[0], 32'd0);
        check("rst_after_outputs", {28'd0, cpu_rsp_valid[0], host_rsp_valid[0], mem_wren[0], mem_rden[0]}, 32'd0);
        idle_cycles(1);
        do_req(0, 1'b0, 1'b0, 11'h004, 32'h0, 32'h1234_5678, s_c, a_c);
        check("rst_after_next_stalls", s_c, 0);
        idle_cycles(3);

        // Halt rising during an in-flight RD_LAT=1 CPU read
        fork
            do_req(1, 1'b0, 1'b0, 11'h008, 32'h0, 32'hA5A5_0008, s_c, a_c);
            begin
                @(negedge clk);
                @(posedge clk);
                #1;
                cpu_halt[1] = 1'b1;
                do_req(1, 1'b1, 1'b0, 11'h004, 32'h0, 32'h1234_5678, s_h, a_h);
            end
        join
        check("halt_inflight_cpu_stalls", s_c, 0);
        check("halt_inflight_host_grant_cycle", a_h - a_c, 3);
        idle_cycles(4);
        cpu_halt[1] = 1'b0;

        check("pending_rsp_left", q_cpu0.size() + q_cpu1.size() + q_host0.size() + q_host1.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: got running, required finished");
        $fatal(1);
    end

endmodule
